scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameters SHALL be: LOG2_NR, default 4, register index width; REG_BITS, default 8, bits per register; NSHIFT, default 2, bits shifted per scan cycle.
REQ-002 Ports SHALL be as listed below; W = LOG2_NR, B = $clog2(REG_BITS*2/NSHIFT).
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  operation request.
- req_ready  out  1  sequencer can accept a request.
- req_wide  in  1  1 = 16-bit register pair, 0 = 8-bit register.
- req_reg, req_reg2  in  W  port 1 / port 2 register index.
- req_use2  in  1  port 2 participates.
- req_wr, req_wr2  in  1  port writes data_in, else rotates its own scan_out.
- stall  in  1  freeze scanning this cycle.
- reg_index, reg_index2  out  W  to register file.
- do_scan, do_scan2  out  1  to register file.
- bit_index  out  B  scan position to register file.
- scan_in, scan_in2  out  NSHIFT  to register file.
- scan_out, scan_out2  in  NSHIFT  from register file.
- data_out, data_out2  out  NSHIFT  serial operands to ALU.
- data_in, data_in2  in  NSHIFT  serial results from ALU.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; request rejected.

Function
REQ-003 The state machine SHALL have states IDLE, SCAN and DONE; req_ready SHALL be 1 only in IDLE.
REQ-004 On req_valid && req_ready, the block SHALL capture all req_* fields and enter SCAN (or DONE with err, per REQ-011) on the next cycle, with bit_index = 0.
REQ-005 SCAN SHALL last N = REG_BITS/NSHIFT non-stalled cycles when narrow (4 by default) and 2N cycles when wide (8 by default); bit_index SHALL increment by 1 per non-stalled cycle.
REQ-006 When narrow, reg_index SHALL equal the captured req_reg; when wide, reg_index SHALL be {req_reg[W-1:1],0} while bit_index < N and {req_reg[W-1:1],1} after; port 2 SHALL be mapped the same way.
REQ-007 do_scan SHALL be 1 in SCAN when stall = 0 and 0 otherwise; do_scan2 SHALL additionally require use2 = 1 and reg_index2 != reg_index.
REQ-008 scan_in SHALL equal data_in when wr = 1 and scan_out when wr = 0 (rotate, preserving contents); scan_in2 SHALL follow the same rule using wr2, data_in2 and scan_out2.
REQ-009 data_out SHALL equal scan_out; data_out2 SHALL equal scan_out when use2 = 1 and the port indices match, and scan_out2 otherwise; both are combinational.
REQ-010 With stall = 1, the block SHALL hold bit_index and all indices and SHALL NOT advance state.
REQ-011 A request with req_use2 = 1 whose two indices both have top bit set (special range) and differ SHALL perform no scan, SHALL go directly to DONE with err = 1, and SHALL leave do_scan and do_scan2 at 0 throughout.
REQ-012 After the last non-stalled SCAN cycle, the block SHALL enter DONE for exactly one cycle with done = 1, then return to IDLE.
REQ-013 The total latency SHALL be: accept at cycle T, done at cycle T+N+1 (narrow) or T+2N+1 (wide) plus stalled cycles, and req_ready at T+N+2 (narrow) or T+2N+2 (wide) plus stalled cycles.
REQ-014 err SHALL be 0 whenever done = 0.
REQ-015 bit_index SHALL be 0 in IDLE and DONE; the counter SHALL NOT wrap within an operation.

Reset
REQ-016 With reset_n = 0, the block SHALL immediately enter IDLE with req_ready = 1 and done, err, do_scan, do_scan2, bit_index, reg_index and reg_index2 all 0, independent of clk.
REQ-017 A reset asserted mid-SCAN SHALL abort the operation with no done pulse; register contents are then partially rotated, which is acceptable.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Narrow rotate: req_reg = 3, wr = 0, use2 = 0 -> do_scan high 4 cycles, reg_index = 3, bit_index 0..3, done at T+5; r3 unchanged.
- Wide write: req_reg = 5, wr = 1, data_in = 2'b01 constant -> reg_index 4 for 4 cycles then 5 for 4 cycles; r4 = r5 = 8'h55; done at T+9.
- Same index: req_reg = req_reg2 = 2, use2 = 1 -> do_scan2 = 0 throughout; data_out2 == data_out every cycle.
- Stall: narrow op with stall = 1 at the second scan cycle for 3 cycles -> bit_index holds at 1; done at T+8.
- Special conflict: req_reg = 8, req_reg2 = 10, use2 = 1 -> no do_scan; done = err = 1 at T+1.
- Reset mid-scan: reset_n = 0 at bit_index = 2 -> outputs reset immediately, no done pulse; req_ready = 1 after release.

Source files
------------

// File: rtl/scan_sequencer_if.sv
// rtl/scan_sequencer_if.sv - request, register-file and ALU signal bundle for scan_sequencer
//
// Ports (from the sequencer's point of view, modport slave):
//   request : req_valid/req_ready handshake plus req_wide, req_reg, req_reg2,
//             req_use2, req_wr, req_wr2 and the stall freeze input
//   regfile : reg_index(2), do_scan(2), bit_index, scan_in(2) out; scan_out(2) in
//   alu     : data_out(2) out, data_in(2) in
//   status  : done pulse, err qualifier
// modport master is the requester / register file / ALU side.
interface scan_sequencer_if #(
    parameter int LOG2_NR  = 4,
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
);
    localparam int W = LOG2_NR;
    localparam int B = $clog2(REG_BITS * 2 / NSHIFT);

    logic              req_valid;
    logic              req_ready;
    logic              req_wide;
    logic [W-1:0]      req_reg;
    logic [W-1:0]      req_reg2;
    logic              req_use2;
    logic              req_wr;
    logic              req_wr2;
    logic              stall;
    logic [W-1:0]      reg_index;
    logic [W-1:0]      reg_index2;
    logic              do_scan;
    logic              do_scan2;
    logic [B-1:0]      bit_index;
    logic [NSHIFT-1:0] scan_in;
    logic [NSHIFT-1:0] scan_in2;
    logic [NSHIFT-1:0] scan_out;
    logic [NSHIFT-1:0] scan_out2;
    logic [NSHIFT-1:0] data_out;
    logic [NSHIFT-1:0] data_out2;
    logic [NSHIFT-1:0] data_in;
    logic [NSHIFT-1:0] data_in2;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_wide, req_reg, req_reg2, req_use2, req_wr, req_wr2,
        output stall, scan_out, scan_out2, data_in, data_in2,
        input  req_ready, reg_index, reg_index2, do_scan, do_scan2, bit_index,
        input  scan_in, scan_in2, data_out, data_out2, done, err
    );

    modport slave (
        input  req_valid, req_wide, req_reg, req_reg2, req_use2, req_wr, req_wr2,
        input  stall, scan_out, scan_out2, data_in, data_in2,
        output req_ready, reg_index, reg_index2, do_scan, do_scan2, bit_index,
        output scan_in, scan_in2, data_out, data_out2, done, err
    );
endinterface

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - bit-serial register scan sequencer for a two-port register file
//
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : scan_sequencer_if.slave (request handshake, register-file scan
//              controls, serial ALU operands/results, done/err status)
//
// A request walks one register (narrow) or an even/odd register pair (wide)
// NSHIFT bits per cycle. Each port either rotates its register through
// scan_out -> scan_in, or overwrites it with the ALU result on data_in.
module scan_sequencer #(
    parameter int LOG2_NR  = 4,
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    scan_sequencer_if.slave  bus
);
    localparam int W = LOG2_NR;
    localparam int N = REG_BITS / NSHIFT;
    localparam int B = $clog2(REG_BITS * 2 / NSHIFT);

    localparam logic [B-1:0] CNT_ONE       = B'(1);
    localparam logic [B-1:0] CNT_HALF      = B'(N);
    localparam logic [B-1:0] CNT_LAST_NARR = B'(N - 1);
    localparam logic [B-1:0] CNT_LAST_WIDE = B'(2 * N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state;
    logic [B-1:0] bit_cnt;
    logic         wide_q;
    logic         use2_q;
    logic         wr_q;
    logic         wr2_q;
    logic         err_q;
    logic [W-1:0] reg_q;
    logic [W-1:0] reg2_q;

    logic         special_conflict;
    logic         last_scan;
    logic         upper_half;
    logic [W-1:0] idx1;
    logic [W-1:0] idx2;
    logic         ports_match;
    logic         in_scan;

    // Both indices in the top (special) half and different cannot be served
    // by the two-port file; such requests are rejected without scanning.
    assign special_conflict = bus.req_use2 && bus.req_reg[W-1] && bus.req_reg2[W-1]
                              && (bus.req_reg != bus.req_reg2);

    assign last_scan  = (bit_cnt == (wide_q ? CNT_LAST_WIDE : CNT_LAST_NARR));
    assign upper_half = (bit_cnt >= CNT_HALF);

    // Wide operations visit the even register of the pair first, then the odd one.
    assign idx1 = wide_q ? {reg_q[W-1:1],  upper_half} : reg_q;
    assign idx2 = wide_q ? {reg2_q[W-1:1], upper_half} : reg2_q;

    assign ports_match = use2_q && (idx1 == idx2);
    assign in_scan     = (state == ST_SCAN);

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.err        = (state == ST_DONE) && err_q;
    assign bus.bit_index  = bit_cnt;
    assign bus.reg_index  = in_scan ? idx1 : '0;
    assign bus.reg_index2 = in_scan ? idx2 : '0;
    assign bus.do_scan    = in_scan && !bus.stall;
    // A shared register is rotated by port 1 only, so port 2 must not write it back.
    assign bus.do_scan2   = in_scan && !bus.stall && use2_q && (idx1 != idx2);

    assign bus.scan_in    = wr_q  ? bus.data_in  : bus.scan_out;
    assign bus.scan_in2   = wr2_q ? bus.data_in2 : bus.scan_out2;
    assign bus.data_out   = bus.scan_out;
    assign bus.data_out2  = ports_match ? bus.scan_out : bus.scan_out2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            wide_q  <= 1'b0;
            use2_q  <= 1'b0;
            wr_q    <= 1'b0;
            wr2_q   <= 1'b0;
            err_q   <= 1'b0;
            reg_q   <= '0;
            reg2_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        wide_q  <= bus.req_wide;
                        use2_q  <= bus.req_use2;
                        wr_q    <= bus.req_wr;
                        wr2_q   <= bus.req_wr2;
                        reg_q   <= bus.req_reg;
                        reg2_q  <= bus.req_reg2;
                        err_q   <= special_conflict;
                        bit_cnt <= '0;
                        state   <= special_conflict ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!bus.stall) begin
                        if (last_scan) begin
                            bit_cnt <= '0;
                            state   <= ST_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - self-checking bench for scan_sequencer
module tb_scan_sequencer;
    localparam int LOG2_NR  = 4;
    localparam int REG_BITS = 8;
    localparam int NSHIFT   = 2;
    localparam int N        = REG_BITS / NSHIFT;
    localparam int NR       = 1 << LOG2_NR;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    scan_sequencer_if #(.LOG2_NR(LOG2_NR), .REG_BITS(REG_BITS), .NSHIFT(NSHIFT)) bus ();

    scan_sequencer #(.LOG2_NR(LOG2_NR), .REG_BITS(REG_BITS), .NSHIFT(NSHIFT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Register file environment driven by the DUT's scan controls.
    logic [REG_BITS-1:0] rf      [NR];
    logic [REG_BITS-1:0] rf_init [NR];
    logic                rf_load;
    int                  p1;
    int                  p2;

    always_comb begin
        p1 = int'(bus.bit_index) % N;
        p2 = int'(bus.bit_index) % N;
        bus.scan_out  = rf[bus.reg_index][p1*NSHIFT +: NSHIFT];
        bus.scan_out2 = rf[bus.reg_index2][p2*NSHIFT +: NSHIFT];
    end

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < NR; i++) rf[i] <= rf_init[i];
        end else begin
            if (bus.do_scan)  rf[bus.reg_index][p1*NSHIFT +: NSHIFT]  <= bus.scan_in;
            if (bus.do_scan2) rf[bus.reg_index2][p2*NSHIFT +: NSHIFT] <= bus.scan_in2;
        end
    end

    // Reference register contents.
    logic [REG_BITS-1:0] mm [NR];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string nm);
        for (int i = 0; i < NR; i++)
            check($sformatf("%s:r%0d", nm, i), 32'(rf[i]), 32'(mm[i]));
    endtask

    // Register holding chunk k of an operand rooted at r.
    function automatic int chunk_reg(input int r, input logic wide, input int k);
        return wide ? ((r & ~1) + k / N) : r;
    endfunction

    task automatic run_op(input string nm, input logic wide, input logic [3:0] r, input logic [3:0] r2,
                          input logic use2, input logic wr, input logic wr2,
                          input int stall_at, input int stall_len, input bit rand_stall,
                          input bit cdata_en, input logic [1:0] cdata, input int exp_done);
        logic [1:0] din_log [$];
        logic [1:0] din2_log [$];
        logic [1:0] d1, d2, o1, o2own, o2;
        logic       special, same, st;
        int         s_total, k, c_done, ri1, ri2, pos;

        special = use2 && r[3] && r2[3] && (r != r2);
        s_total = special ? 0 : (wide ? 2 * N : N);
        same    = use2 && (wide ? ((r >> 1) == (r2 >> 1)) : (r == r2));

        @(negedge clk);
        #1;
        check({nm, ":ready_before"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_wide  = wide;
        bus.req_reg   = r;
        bus.req_reg2  = r2;
        bus.req_use2  = use2;
        bus.req_wr    = wr;
        bus.req_wr2   = wr2;

        k      = 0;
        c_done = 0;
        for (int c = 1; c <= 60 && c_done == 0; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (k < s_total)
                st = rand_stall ? ($urandom_range(0, 3) == 0)
                                : (stall_at > 0 && c >= stall_at && c < stall_at + stall_len);
            else
                st = 1'b0;
            d1 = cdata_en ? cdata : 2'($urandom);
            d2 = 2'($urandom);
            bus.stall    = st;
            bus.data_in  = d1;
            bus.data_in2 = d2;
            #1;
            if (k < s_total) begin
                pos = k % N;
                ri1 = chunk_reg(int'(r), wide, k);
                o1  = mm[ri1][pos*2 +: 2];
                check({nm, ":done_early"}, 32'(bus.done), 32'd0);
                check({nm, ":ready_busy"}, 32'(bus.req_ready), 32'd0);
                check({nm, ":bit_index"}, 32'(bus.bit_index), 32'(k));
                check({nm, ":reg_index"}, 32'(bus.reg_index), 32'(ri1));
                check({nm, ":do_scan"}, 32'(bus.do_scan), 32'(!st));
                check({nm, ":data_out"}, 32'(bus.data_out), 32'(o1));
                check({nm, ":scan_in"}, 32'(bus.scan_in), 32'(wr ? d1 : o1));
                if (use2) begin
                    ri2   = chunk_reg(int'(r2), wide, k);
                    o2own = mm[ri2][pos*2 +: 2];
                    o2    = same ? o1 : o2own;
                    check({nm, ":reg_index2"}, 32'(bus.reg_index2), 32'(ri2));
                    check({nm, ":do_scan2"}, 32'(bus.do_scan2), 32'(!st && !same));
                    check({nm, ":data_out2"}, 32'(bus.data_out2), 32'(o2));
                    check({nm, ":scan_in2"}, 32'(bus.scan_in2), 32'(wr2 ? d2 : o2own));
                end else begin
                    check({nm, ":do_scan2_off"}, 32'(bus.do_scan2), 32'd0);
                end
                if (!st) begin
                    din_log.push_back(d1);
                    din2_log.push_back(d2);
                    k++;
                end
            end else begin
                c_done = c;
                check({nm, ":done"}, 32'(bus.done), 32'd1);
                check({nm, ":err"}, 32'(bus.err), 32'(special));
                check({nm, ":do_scan_done"}, 32'(bus.do_scan), 32'd0);
                check({nm, ":do_scan2_done"}, 32'(bus.do_scan2), 32'd0);
                check({nm, ":bit_index_done"}, 32'(bus.bit_index), 32'd0);
                check({nm, ":ready_in_done"}, 32'(bus.req_ready), 32'd0);
            end
        end
        if (c_done == 0) check({nm, ":timeout"}, 32'd0, 32'd1);
        if (exp_done > 0) check({nm, ":latency"}, 32'(c_done), 32'(exp_done));

        @(negedge clk);
        #1;
        check({nm, ":ready_after"}, 32'(bus.req_ready), 32'd1);
        check({nm, ":done_after"}, 32'(bus.done), 32'd0);
        check({nm, ":err_after"}, 32'(bus.err), 32'd0);
        check({nm, ":bit_index_idle"}, 32'(bus.bit_index), 32'd0);

        for (int j = 0; j < s_total; j++) begin
            pos = j % N;
            ri1 = chunk_reg(int'(r), wide, j);
            ri2 = chunk_reg(int'(r2), wide, j);
            if (wr) mm[ri1][pos*2 +: 2] = din_log[j];
            if (use2 && !same && wr2) mm[ri2][pos*2 +: 2] = din2_log[j];
        end
        check_regs(nm);
    endtask

    initial begin
        logic [REG_BITS-1:0] r3_before;

        reset_n       = 1'b0;
        rf_load       = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wide  = 1'b0;
        bus.req_reg   = '0;
        bus.req_reg2  = '0;
        bus.req_use2  = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_wr2   = 1'b0;
        bus.stall     = 1'b0;
        bus.data_in   = '0;
        bus.data_in2  = '0;
        for (int i = 0; i < NR; i++) begin
            rf_init[i] = 8'($urandom);
            mm[i]      = rf_init[i];
        end

        @(negedge clk);
        #1;
        check("rst:req_ready", 32'(bus.req_ready), 32'd1);
        check("rst:done", 32'(bus.done), 32'd0);
        check("rst:err", 32'(bus.err), 32'd0);
        check("rst:do_scan", 32'(bus.do_scan), 32'd0);
        check("rst:do_scan2", 32'(bus.do_scan2), 32'd0);
        check("rst:bit_index", 32'(bus.bit_index), 32'd0);
        check("rst:reg_index", 32'(bus.reg_index), 32'd0);
        check("rst:reg_index2", 32'(bus.reg_index2), 32'd0);
        rf_load = 1'b0;
        reset_n = 1'b1;

        r3_before = rf_init[3];
        run_op("narrow_rot", 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 2'b00, 5);
        check("narrow_rot:r3_kept", 32'(rf[3]), 32'(r3_before));

        run_op("wide_wr", 1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 2'b01, 9);
        check("wide_wr:r4", 32'(rf[4]), 32'h55);
        check("wide_wr:r5", 32'(rf[5]), 32'h55);

        run_op("same_idx", 1'b0, 4'd2, 4'd2, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 2'b00, 5);
        run_op("stall", 1'b0, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 2, 3, 1'b0, 1'b0, 2'b00, 8);
        run_op("special", 1'b0, 4'd8, 4'd10, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 2'b00, 1);

        // Reset in the middle of a narrow rotate.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wide  = 1'b0;
        bus.req_reg   = 4'd6;
        bus.req_use2  = 1'b0;
        bus.req_wr    = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rstmid:bit_index_pre", 32'(bus.bit_index), 32'd2);
        check("rstmid:do_scan_pre", 32'(bus.do_scan), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid:req_ready", 32'(bus.req_ready), 32'd1);
        check("rstmid:do_scan", 32'(bus.do_scan), 32'd0);
        check("rstmid:bit_index", 32'(bus.bit_index), 32'd0);
        check("rstmid:reg_index", 32'(bus.reg_index), 32'd0);
        check("rstmid:done", 32'(bus.done), 32'd0);
        check("rstmid:err", 32'(bus.err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rstmid:no_done", 32'(bus.done), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid:ready_release", 32'(bus.req_ready), 32'd1);
        check("rstmid:done_release", 32'(bus.done), 32'd0);
        check_regs("rstmid");

        for (int t = 0; t < 40; t++) begin
            run_op($sformatf("rand%0d", t), 1'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 1'b1, 1'b0, 2'b00, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
